// File: rtl/master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : master_pkg
//  Description : Shared types and bus encodings for the bus-master wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package master_pkg;

    // Transfer sequencing states of the bus master
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timeout_counter
//  Description : Data-phase watchdog. Counts cycles while enabled and flags
//                expiry once TIMEOUT-1 waiting cycles have elapsed.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == LAST);

    // Next count: clear wins, otherwise count up and saturate at the limit
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/master_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : master_wrapper
//  Description : Bus master between the CPU memory port and the shared bus.
//                Captures one load/store, arbitrates for the bus, runs the
//                address and data phases, and returns data with a one-cycle
//                completion pulse. A watchdog aborts stuck data phases.
//  Revision    : 1.0 - initial release
// ============================================================================
module master_wrapper
    import master_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    // CPU side
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic        cpu_err,
    // Bus side
    output logic        HBusReq,
    output logic [31:0] HAddress,
    output logic        HWrite,
    output logic [31:0] HWrite_data,
    output logic [1:0]  HTrans,
    input  logic        HGrant,
    input  logic        HReady,
    input  logic [1:0]  HResp,
    input  logic [31:0] HRead_data
);

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        write_q, write_d;
    logic        err_q,   err_d;

    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;

    // Watchdog runs only in the data phase and counts cycles the slave stalls
    assign tmo_clear  = (state_q != DATA);
    assign tmo_enable = (state_q == DATA) && !HReady;

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant only matters in REQ, ready/timeout only in DATA
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req)                 state_d = REQ;
            REQ:     if (HGrant)                  state_d = DATA;
            DATA:    if (HReady || tmo_expired)   state_d = DONE;
            DONE:                                 state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Request capture in IDLE, read-data and status capture at data-phase end
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == IDLE && cpu_req) begin
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            write_d = cpu_write;
        end
        if (state_q == DATA) begin
            if (HReady) begin
                // Stores leave the last load value visible to the CPU
                if (!write_q) begin
                    rdata_d = HRead_data;
                end
                err_d = (HResp == HRESP_ERROR);
            end else if (tmo_expired) begin
                err_d = 1'b1;
            end
        end
    end

    // Request, read-data and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_rdata = rdata_q;

    // Output decode from the current state
    always_comb begin
        cpu_stall   = 1'b0;
        cpu_done    = 1'b0;
        cpu_err     = 1'b0;
        HBusReq     = 1'b0;
        HAddress    = '0;
        HWrite      = 1'b0;
        HWrite_data = '0;
        HTrans      = HTRANS_IDLE;
        case (state_q)
            IDLE: begin
                cpu_stall = cpu_req;
            end
            REQ: begin
                cpu_stall   = 1'b1;
                HBusReq     = 1'b1;
                HTrans      = HTRANS_NONSEQ;
                HAddress    = addr_q;
                HWrite      = write_q;
                HWrite_data = wdata_q;
            end
            DATA: begin
                cpu_stall   = 1'b1;
                HWrite_data = wdata_q;
            end
            DONE: begin
                cpu_done = 1'b1;
                cpu_err  = err_q;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_master_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_master_wrapper
//  Description : Scoreboard bench for master_wrapper. Each issued transfer
//                pushes its expected completion cycle, read data and error
//                flag; a monitor pops and compares on every cpu_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_master_wrapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        cpu_err;
    logic        HBusReq;
    logic [31:0] HAddress;
    logic        HWrite;
    logic [31:0] HWrite_data;
    logic [1:0]  HTrans;
    logic        HGrant;
    logic        HReady;
    logic [1:0]  HResp;
    logic [31:0] HRead_data;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    master_wrapper #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_write   (cpu_write),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .cpu_done    (cpu_done),
        .cpu_err     (cpu_err),
        .HBusReq     (HBusReq),
        .HAddress    (HAddress),
        .HWrite      (HWrite),
        .HWrite_data (HWrite_data),
        .HTrans      (HTrans),
        .HGrant      (HGrant),
        .HReady      (HReady),
        .HResp       (HResp),
        .HRead_data  (HRead_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && cpu_done === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done @cycle %0d: got cpu_done=1, expected no pending transfer", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL done_cycle: got %0d, expected %0d", cyc, e.cyc);
                end
                chk("done_rdata", cpu_rdata, e.rdata);
                chk("done_err", {31'd0, cpu_err}, {31'd0, e.err});
            end
        end
    end

    // One transfer: gd grant-wait cycles, rd ready-low data cycles (or never)
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gd, input int rd, input logic never,
                           input logic [1:0] resp, input logic [31:0] hrdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int   t0;
        int   breq_cnt;
        exp_t e;
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
        HGrant = 1'b0; HReady = 1'b0; HResp = 2'b00; HRead_data = 32'h0;
        t0 = cyc;
        e.cyc = t0 + exp_lat; e.rdata = exp_rdata; e.err = exp_err;
        sb.push_back(e);
        #1 chk("stall_on_req", {31'd0, cpu_stall}, 32'd1);
        breq_cnt = 0;
        for (int k = 1; k <= exp_lat; k++) begin
            @(negedge clk);
            // CPU inputs scrambled after capture; a request in DONE must be ignored
            cpu_req    = (k == exp_lat);
            cpu_addr   = ~addr;
            cpu_wdata  = ~wdata;
            cpu_write  = ~wr;
            HGrant     = (k == 1 + gd);
            HReady     = (!never && k == 2 + gd + rd) || (k >= 1 && k <= gd);
            HResp      = (!never && k == 2 + gd + rd) ? resp : 2'b00;
            HRead_data = (k == 2 + gd + rd) ? hrdata : 32'hBAD0_BAD0;
            #1;
            if (HBusReq === 1'b1) breq_cnt++;
            if (k == 1 + gd) begin
                chk("grant_haddr", HAddress, addr);
                chk("grant_hwrite", {31'd0, HWrite}, {31'd0, wr});
                chk("grant_hwdata", HWrite_data, wdata);
                chk("grant_htrans", {30'd0, HTrans}, 32'd2);
            end
            if (k < exp_lat) chk("stall_busy", {31'd0, cpu_stall}, 32'd1);
            else             chk("stall_done", {31'd0, cpu_stall}, 32'd0);
        end
        chk("hbusreq_cycles", breq_cnt, gd + 1);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL done_missing: got %0d pending, expected 0 (due cycle %0d)", sb.size(), t0 + exp_lat);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        HGrant = 1'b0; HReady = 1'b0; HResp = 2'b00; HRead_data = 32'h0;
        #1;
        chk("rst_hbusreq", {31'd0, HBusReq}, 32'd0);
        chk("rst_htrans", {30'd0, HTrans}, 32'd0);
        chk("rst_haddr", HAddress, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_done", {31'd0, cpu_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Best-case load
        run_txn(1'b0, 32'h0000_0040, 32'h0, 0, 0, 1'b0, 2'b00, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 1'b0, 3);
        // Store with 4 grant-wait cycles (stray HReady during REQ), rdata kept
        run_txn(1'b1, 32'h0000_0080, 32'h1234_5678, 4, 0, 1'b0, 2'b00, 32'h5555_5555,
                32'hDEAD_BEEF, 1'b0, 7);
        // Load with 3 ready-low cycles, HResp=2'b10 counts as OKAY
        run_txn(1'b0, 32'h0000_0100, 32'h0, 0, 3, 1'b0, 2'b10, 32'hCAFE_F00D,
                32'hCAFE_F00D, 1'b0, 6);
        // Ready never arrives: abort 16 cycles after DATA entry
        run_txn(1'b0, 32'h0000_0200, 32'h0, 0, 0, 1'b1, 2'b00, 32'h0,
                32'hCAFE_F00D, 1'b1, 18);
        // Error response on completion
        run_txn(1'b0, 32'h0000_0204, 32'h0, 1, 0, 1'b0, 2'b01, 32'h1111_2222,
                32'h1111_2222, 1'b1, 4);

        // Asynchronous reset while in DATA
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0300; cpu_wdata = 32'h0;
        @(negedge clk);
        cpu_req = 1'b0; HGrant = 1'b1;
        @(negedge clk);
        HGrant = 1'b0; HReady = 1'b0;
        #1 chk("pre_rst_stall", {31'd0, cpu_stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_hbusreq", {31'd0, HBusReq}, 32'd0);
        chk("arst_htrans", {30'd0, HTrans}, 32'd0);
        chk("arst_hwdata", HWrite_data, 32'd0);
        chk("arst_rdata", cpu_rdata, 32'd0);
        chk("arst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("arst_done", {31'd0, cpu_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Normal transfer after reset release
        run_txn(1'b0, 32'h0000_0044, 32'h0, 0, 0, 1'b0, 2'b00, 32'h55AA_55AA,
                32'h55AA_55AA, 1'b0, 3);

        @(negedge clk);
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_hbusreq", {31'd0, HBusReq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
